cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Result-writeback stage directly downstream of the ALU reservation/execute unit and its sibling execution units.
- Each unit's per-cycle (target tag, result) output is captured into a private small FIFO.
- A round-robin arbiter drives at most one result per cycle onto the common data bus, which the ROB consumes.
- Supplies registered per-source back-pressure so execution units stop issuing before their FIFO overflows.

Parameters:
- SRC_NUM, 2, number of execution-unit sources (index 0 = ALU).
- FIFO_DEPTH, 4, entries per source FIFO (power of two, >= 2).
- TAG_WIDTH, 4, instruction tag width; the all-ones value is the invalid tag.
- DATA_WIDTH, 32, result width.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- src_target  input  SRC_NUM*TAG_WIDTH  per-source result tag; slice i belongs to source i; the invalid tag means no result.
- src_result  input  SRC_NUM*DATA_WIDTH  per-source result value.
- src_full  output  SRC_NUM  per-source registered back-pressure.
- rob_stall  input  1  ROB cannot accept a broadcast this cycle.
- cdb_valid  output  1  broadcast valid.
- cdb_target  output  TAG_WIDTH  broadcast tag.
- cdb_result  output  DATA_WIDTH  broadcast value.
- cdb_src  output  clog2(SRC_NUM) (min 1)  index of the granted source, for debug and perf counters.
- overflow  output  1  sticky error flag: a push arrived while a FIFO was full.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - FIFO counts, read and write pointers = 0; rr_ptr = 0.
  - cdb_valid = 0; cdb_target = all-ones (invalid); cdb_result = 0; cdb_src = 0.
  - src_full = 0; overflow = 0.
  - Reset asserted mid-operation discards all buffered results immediately, with no broadcast.
- Push:
  - At each rising edge, source i pushes when its src_target slice is not the invalid tag.
  - A push needs no handshake beyond src_full.
- Pop and grant:
  - Pop happens only when rob_stall = 0 and at least one FIFO is non-empty.
  - The grant goes to the first non-empty source scanning i = rr_ptr, rr_ptr+1, … modulo SRC_NUM.
  - The granted head entry is registered onto cdb_target/cdb_result with cdb_valid = 1 and cdb_src = granted index.
  - rr_ptr <= (granted + 1) mod SRC_NUM.
- No pop:
  - Applies when rob_stall = 1 or all FIFOs are empty.
  - cdb_valid <= 0 and cdb_target <= invalid tag; cdb_result holds its value; rr_ptr is unchanged.
- Latency:
  - A result pushed at edge k is broadcast no earlier than edge k+1, i.e. one cycle minimum.
  - There is no same-cycle bypass from input to cdb.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Back-pressure:
  - src_full[i] is registered: src_full[i] <= (count_next[i] >= FIFO_DEPTH-1).
  - The one-entry margin absorbs the push a source makes in the cycle it first observes full.
- Overflow:
  - A push into a FIFO with count == FIFO_DEPTH and no simultaneous pop on it is dropped.
  - The drop sets overflow, which stays set until reset.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Fairness: a source with a continuously non-empty FIFO is granted at least once every SRC_NUM non-stalled cycles.
- Tags pass through unmodified; the block does not check tag uniqueness.

Decomposition:
- Shared package:
  - TAG_INVALID constant (all-ones of TAG_WIDTH).
  - cdb_entry_t struct {target, result}.
  - Source-index enum (SRC_ALU = 0, SRC_MEM = 1).
- Sub-module wb_fifo: a single-source FIFO with push, pop, head data, count, and full_margin output; instantiated SRC_NUM times in a generate loop.
- The round-robin priority scan stays inline in cdb_arbiter.

Test Plan:
- Single push: source 0 pushes tag 3 / value 0x0000_002A at edge 1 → at edge 2, cdb_valid = 1, cdb_target = 3, cdb_result = 0x2A, cdb_src = 0; at edge 3, cdb_valid = 0, cdb_target = 0xF.
- Collision:
  - Stimulus: both sources push at edge 1 (src0 tag 1 / 0x11, src1 tag 2 / 0x22), rr_ptr = 0.
  - Required response: edge 2 broadcasts tag 1 (src 0); edge 3 broadcasts tag 2 (src 1); rr_ptr ends at 0.
- Back-pressure:
  - Stimulus: rob_stall = 1; source 0 pushes tags 0, 1, 2 on consecutive edges.
  - Required response: src_full[0] = 1 after the third push (count 3 = DEPTH-1); one further push is accepted with overflow = 0; a fifth push sets overflow = 1 and is dropped.
- Stall release: continuing the previous case, rob_stall → 0 → tags 0, 1, 2, 3 are broadcast in order on 4 consecutive edges, and src_full[0] clears when count falls below 3.
- Fairness: both FIFOs held non-empty for 8 cycles → the grant alternates 0, 1, 0, 1, …, with exactly 4 grants per source.
- Async reset mid-stream: rst is asserted between edges while 2 entries are buffered → cdb_valid, src_full, and overflow drop to 0 immediately, without waiting for clk, and no buffered tag is broadcast after rst deasserts.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the result-writeback (common data bus) stage.
package cdb_arbiter_pkg;

   // Default widths of the tag and result fields carried on the bus.
   localparam int CDB_TAG_WIDTH  = 4;
   localparam int CDB_DATA_WIDTH = 32;

   // All-ones tag marks "no result" on both the source inputs and the bus.
   localparam logic [CDB_TAG_WIDTH-1:0] TAG_INVALID = '1;

   // One buffered writeback: destination tag plus result value.
   typedef struct packed {
      logic [CDB_TAG_WIDTH-1:0]  target;
      logic [CDB_DATA_WIDTH-1:0] result;
   } cdb_entry_t;

   // Execution-unit source indices; the ALU is always source 0.
   typedef enum logic [0:0] {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_id_t;

   // Width of a source index, never less than one bit.
   function automatic int src_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// Single-source writeback FIFO: captures one (tag, result) per cycle,
// exposes the head combinationally and a registered one-entry-margin full flag.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full_margin,
   output logic                    drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             full_reg;
   logic             pop_ok;
   logic             accept;

   // A pop frees a slot in the same cycle, so a push into a full FIFO
   // is still accepted when the head is leaving.
   assign pop_ok     = pop && (count_reg != '0);
   assign accept     = push && ((count_reg != CNT_W'(DEPTH)) || pop_ok);
   assign drop       = push && !accept;
   assign count_next = count_reg + {{(CNT_W-1){1'b0}}, accept}
                                 - {{(CNT_W-1){1'b0}}, pop_ok};

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers, occupancy and the early-warning full flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
         full_reg  <= (count_next >= CNT_W'(DEPTH - 1));
      end
   end

   assign head_data   = mem[rd_ptr_reg];
   assign count       = count_reg;
   assign full_margin = full_reg;

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: one FIFO per execution unit, round-robin grant of at
// most one result per cycle onto the registered common data bus.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int SRC_NUM    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
   parameter int DATA_WIDTH = CDB_DATA_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [SRC_NUM*TAG_WIDTH-1:0]        src_target,
   input  logic [SRC_NUM*DATA_WIDTH-1:0]       src_result,
   output logic [SRC_NUM-1:0]                  src_full,
   input  logic                                rob_stall,
   output logic                                cdb_valid,
   output logic [TAG_WIDTH-1:0]                cdb_target,
   output logic [DATA_WIDTH-1:0]               cdb_result,
   output logic [src_idx_width(SRC_NUM)-1:0]   cdb_src,
   output logic                                overflow
);

   localparam int SRC_W   = src_idx_width(SRC_NUM);
   localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TAG_WIDTH-1:0] TAG_NONE = '1;

   logic [SRC_NUM-1:0] push_vec;
   logic [SRC_NUM-1:0] pop_vec;
   logic [SRC_NUM-1:0] drop_vec;
   logic [SRC_NUM-1:0] full_vec;
   logic [SRC_NUM-1:0] nonempty_vec;
   logic [ENTRY_W-1:0] head_data [SRC_NUM];
   logic [CNT_W-1:0]   fifo_count [SRC_NUM];

   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;
   logic [ENTRY_W-1:0] grant_entry;
   logic [SRC_W-1:0]   rr_next;

   logic [SRC_W-1:0]      rr_ptr_reg;
   logic                  cdb_valid_reg;
   logic [TAG_WIDTH-1:0]  cdb_target_reg;
   logic [DATA_WIDTH-1:0] cdb_result_reg;
   logic [SRC_W-1:0]      cdb_src_reg;
   logic                  overflow_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
         assign push_vec[gi]     = (src_target[gi*TAG_WIDTH +: TAG_WIDTH] != TAG_NONE);
         assign pop_vec[gi]      = grant_valid && (grant_idx == SRC_W'(gi));
         assign nonempty_vec[gi] = (fifo_count[gi] != '0);

         wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
         ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push_vec[gi]),
            .push_data   ({src_target[gi*TAG_WIDTH +: TAG_WIDTH],
                           src_result[gi*DATA_WIDTH +: DATA_WIDTH]}),
            .pop         (pop_vec[gi]),
            .head_data   (head_data[gi]),
            .count       (fifo_count[gi]),
            .full_margin (full_vec[gi]),
            .drop        (drop_vec[gi])
         );
      end
   endgenerate

   // Round-robin scan from rr_ptr; walking backwards lets the nearest
   // non-empty source overwrite farther candidates.
   always_comb begin
      logic [SRC_W:0] cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = SRC_NUM - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
         if (cand >= (SRC_W+1)'(SRC_NUM)) begin
            cand = cand - (SRC_W+1)'(SRC_NUM);
         end
         if (nonempty_vec[cand[SRC_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[SRC_W-1:0];
         end
      end
      grant_valid = grant_valid && !rob_stall;
   end

   // Selected head entry and the pointer value that follows this grant.
   always_comb begin
      grant_entry = head_data[grant_idx];
      if ({1'b0, grant_idx} == (SRC_W+1)'(SRC_NUM - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = grant_idx + SRC_W'(1);
      end
   end

   // Registered bus outputs, round-robin pointer and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_reg     <= '0;
         cdb_valid_reg  <= 1'b0;
         cdb_target_reg <= TAG_NONE;
         cdb_result_reg <= '0;
         cdb_src_reg    <= SRC_W'(SRC_ALU);
         overflow_reg   <= 1'b0;
      end else begin
         if (grant_valid) begin
            cdb_valid_reg  <= 1'b1;
            cdb_target_reg <= grant_entry[ENTRY_W-1 -: TAG_WIDTH];
            cdb_result_reg <= grant_entry[DATA_WIDTH-1:0];
            cdb_src_reg    <= grant_idx;
            rr_ptr_reg     <= rr_next;
         end else begin
            cdb_valid_reg  <= 1'b0;
            cdb_target_reg <= TAG_NONE;
         end
         overflow_reg <= overflow_reg | (|drop_vec);
      end
   end

   assign src_full   = full_vec;
   assign cdb_valid  = cdb_valid_reg;
   assign cdb_target = cdb_target_reg;
   assign cdb_result = cdb_result_reg;
   assign cdb_src    = cdb_src_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a queue-based reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int SRC_NUM    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam logic [3:0] NT = 4'hF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  src_target = 8'hFF;
   logic [63:0] src_result = '0;
   logic [1:0]  src_full;
   logic        rob_stall = 1'b0;
   logic        cdb_valid;
   logic [3:0]  cdb_target;
   logic [31:0] cdb_result;
   logic [0:0]  cdb_src;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .SRC_NUM    (SRC_NUM),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TAG_WIDTH  (4),
      .DATA_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .src_target (src_target),
      .src_result (src_result),
      .src_full   (src_full),
      .rob_stall  (rob_stall),
      .cdb_valid  (cdb_valid),
      .cdb_target (cdb_target),
      .cdb_result (cdb_result),
      .cdb_src    (cdb_src),
      .overflow   (overflow)
   );

   // Reference model: one queue per source, grant from pre-push contents.
   cdb_entry_t  mq [SRC_NUM][$];
   int          m_rr;
   logic        exp_valid;
   logic [3:0]  exp_target;
   logic [31:0] exp_result;
   int          exp_src;
   logic [1:0]  exp_full;
   logic        exp_over;

   always @(posedge clk or posedge rst) begin
      int g;
      int s;
      cdb_entry_t e;
      if (rst) begin
         for (int i = 0; i < SRC_NUM; i++) mq[i].delete();
         m_rr       <= 0;
         exp_valid  <= 1'b0;
         exp_target <= NT;
         exp_result <= '0;
         exp_src    <= 0;
         exp_full   <= '0;
         exp_over   <= 1'b0;
      end else begin
         g = -1;
         if (!rob_stall) begin
            for (int k = 0; k < SRC_NUM; k++) begin
               s = (m_rr + k) % SRC_NUM;
               if (g < 0 && mq[s].size() > 0) g = s;
            end
         end
         if (g >= 0) begin
            e = mq[g].pop_front();
            exp_valid  <= 1'b1;
            exp_target <= e.target;
            exp_result <= e.result;
            exp_src    <= g;
            m_rr       <= (g + 1) % SRC_NUM;
         end else begin
            exp_valid  <= 1'b0;
            exp_target <= NT;
         end
         for (int i = 0; i < SRC_NUM; i++) begin
            if (src_target[i*4 +: 4] != NT) begin
               if (mq[i].size() < FIFO_DEPTH) begin
                  e.target = src_target[i*4 +: 4];
                  e.result = src_result[i*32 +: 32];
                  mq[i].push_back(e);
               end else begin
                  exp_over <= 1'b1;
               end
            end
         end
         for (int i = 0; i < SRC_NUM; i++) begin
            exp_full[i] <= (mq[i].size() >= FIFO_DEPTH - 1);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_model();
      chk("m_valid",  64'(cdb_valid),  64'(exp_valid));
      chk("m_target", 64'(cdb_target), 64'(exp_target));
      chk("m_result", 64'(cdb_result), 64'(exp_result));
      if (exp_valid) chk("m_src", 64'(cdb_src), 64'(exp_src));
      chk("m_full",   64'(src_full),   64'(exp_full));
      chk("m_over",   64'(overflow),   64'(exp_over));
   endtask

   // One clock of stimulus; outputs are sampled on the following falling edge.
   task automatic step(input logic [3:0] t0, input logic [31:0] r0,
                       input logic [3:0] t1, input logic [31:0] r1, input logic st);
      src_target = {t1, t0};
      src_result = {r1, r0};
      rob_stall  = st;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      $display("cyc=%0d in=(%h,%h) stall=%0b -> valid=%0b src=%0d tag=%h data=%h full=%b ovf=%0b",
               cyc, t0, t1, st, cdb_valid, cdb_src, cdb_target, cdb_result, src_full, overflow);
      compare_model();
   endtask

   task automatic idle(input logic st);
      step(NT, 32'h0, NT, 32'h0, st);
   endtask

   task automatic do_reset();
      src_target = 8'hFF;
      rob_stall  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n0, n1;
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_valid",  64'(cdb_valid),  64'd0);
      chk("rst_target", 64'(cdb_target), 64'hF);
      chk("rst_result", 64'(cdb_result), 64'd0);
      chk("rst_src",    64'(cdb_src),    64'd0);
      chk("rst_full",   64'(src_full),   64'd0);
      chk("rst_over",   64'(overflow),   64'd0);
      rst = 1'b0;

      // Single push
      step(4'd3, 32'h2A, NT, 32'h0, 1'b0);
      chk("sp_e1_valid", 64'(cdb_valid), 64'd0);
      idle(1'b0);
      chk("sp_e2_valid",  64'(cdb_valid),  64'd1);
      chk("sp_e2_target", 64'(cdb_target), 64'd3);
      chk("sp_e2_result", 64'(cdb_result), 64'h2A);
      chk("sp_e2_src",    64'(cdb_src),    64'd0);
      idle(1'b0);
      chk("sp_e3_valid",  64'(cdb_valid),  64'd0);
      chk("sp_e3_target", 64'(cdb_target), 64'hF);

      // Collision
      do_reset();
      step(4'd1, 32'h11, 4'd2, 32'h22, 1'b0);
      idle(1'b0);
      chk("col_e2_target", 64'(cdb_target), 64'd1);
      chk("col_e2_src",    64'(cdb_src),    64'd0);
      idle(1'b0);
      chk("col_e3_target", 64'(cdb_target), 64'd2);
      chk("col_e3_src",    64'(cdb_src),    64'd1);
      // rr back at 0: a fresh collision must again favour source 0
      step(4'd5, 32'h55, 4'd6, 32'h66, 1'b0);
      idle(1'b0);
      chk("col_rr0_src", 64'(cdb_src), 64'd0);
      idle(1'b0);

      // Back-pressure
      do_reset();
      step(4'd0, 32'h100, NT, 32'h0, 1'b1);
      step(4'd1, 32'h101, NT, 32'h0, 1'b1);
      chk("bp_full_after2", 64'(src_full[0]), 64'd0);
      step(4'd2, 32'h102, NT, 32'h0, 1'b1);
      chk("bp_full_after3", 64'(src_full[0]), 64'd1);
      step(4'd3, 32'h103, NT, 32'h0, 1'b1);
      chk("bp_over_after4", 64'(overflow), 64'd0);
      step(4'd4, 32'h104, NT, 32'h0, 1'b1);
      chk("bp_over_after5", 64'(overflow), 64'd1);

      // Stall release: tags 0..3 in order, the dropped tag 4 never appears
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         chk("rel_valid",  64'(cdb_valid),  64'd1);
         chk("rel_target", 64'(cdb_target), 64'(i));
         chk("rel_result", 64'(cdb_result), 64'(32'h100 + i));
         chk("rel_full",   64'(src_full[0]), (i == 0) ? 64'd1 : 64'd0);
      end
      idle(1'b0);
      chk("rel_drained", 64'(cdb_valid), 64'd0);

      // Fairness: both FIFOs loaded with 4 entries, then 8 open cycles
      do_reset();
      for (int i = 0; i < 4; i++) step(4'(i), 32'(i), 4'(8 + i), 32'(8 + i), 1'b1);
      chk("fair_full", 64'(src_full), 64'd3);
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 8; k++) begin
         idle(1'b0);
         chk("fair_valid",  64'(cdb_valid),  64'd1);
         chk("fair_src",    64'(cdb_src),    64'(k % 2));
         chk("fair_target", 64'(cdb_target), 64'((k % 2) * 8 + k / 2));
         if (cdb_valid && cdb_src == 1'b0) n0++;
         if (cdb_valid && cdb_src == 1'b1) n1++;
      end
      chk("fair_n0", 64'(n0), 64'd4);
      chk("fair_n1", 64'(n1), 64'd4);

      // Async reset mid-stream with two entries still buffered
      do_reset();
      for (int i = 0; i < 5; i++) step(4'(i), 32'(32'h50 + i), NT, 32'h0, 1'b1);
      idle(1'b0);
      idle(1'b0);
      chk("ar_pre_valid", 64'(cdb_valid), 64'd1);
      chk("ar_pre_over",  64'(overflow),  64'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid",  64'(cdb_valid),  64'd0);
      chk("ar_target", 64'(cdb_target), 64'hF);
      chk("ar_full",   64'(src_full),   64'd0);
      chk("ar_over",   64'(overflow),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         chk("ar_no_bcast", 64'(cdb_valid), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
